tlb_cmd_unit: RTL and testbench

16-entry joint TLB that owns the translation array behind the CP0 Index/EntryHi/EntryLo0/EntryLo1 registers. It executes TLBWI, TLBR and TLBP commands issued from the pipeline, reading CP0 register values and returning results for CP0 write-back. It also provides registered address-translation search ports for instruction fetch and data access.

---
 rtl/tlb_cmd_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tlb_cmd_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_cmd_unit.sv
// tlb_cmd_unit: 16-entry joint TLB running TLBWI/TLBR/TLBP commands plus registered translation search ports.
// Latency: command accepted in N executes in N+1 and responds (resp_valid) in N+2; searches return in the next cycle.
// Backpressure: cmd_ready low outside IDLE; search ports never stall. Port s1 is live only with TLB_DUAL_SEARCH_EN defined.
module tlb_cmd_unit #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic [3:0]  cp0_index,
    input  logic [31:0] cp0_entryhi,
    input  logic [31:0] cp0_entrylo0,
    input  logic [31:0] cp0_entrylo1,
    output logic        resp_valid,
    output logic [1:0]  resp_op,
    output logic [31:0] resp_index,
    output logic [31:0] resp_entryhi,
    output logic [31:0] resp_entrylo0,
    output logic [31:0] resp_entrylo1,
    input  logic        s0_valid,
    input  logic [31:0] s0_vaddr,
    input  logic [7:0]  s0_asid,
    output logic        s0_rvalid,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_pfn,
    output logic [2:0]  s0_c,
    output logic        s0_d,
    output logic        s0_v,
    input  logic        s1_valid,
    input  logic [31:0] s1_vaddr,
    input  logic [7:0]  s1_asid,
    output logic        s1_rvalid,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_pfn,
    output logic [2:0]  s1_c,
    output logic        s1_d,
    output logic        s1_v
);

    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } srch_t;

    state_t            state;
    state_t            state_nxt;
    entry_t            tlb [TLBNUM];
    logic [TLBNUM-1:0] tlb_used;
    entry_t            cap_q;
    logic [1:0]        op_q;
    logic [3:0]        idx_q;
    entry_t            rd_entry;
    srch_t             p_hit;
    srch_t             s0_res;

    // Priority lookup: scanning high to low lets the lowest matching index win.
    function automatic srch_t lookup(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
        srch_t r;
        r = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tlb_used[i] && (tlb[i].vpn2 == vpn2) && (tlb[i].g || (tlb[i].asid == asid))) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
                r.pfn   = odd ? tlb[i].pfn1 : tlb[i].pfn0;
                r.c     = odd ? tlb[i].c1   : tlb[i].c0;
                r.d     = odd ? tlb[i].d1   : tlb[i].d0;
                r.v     = odd ? tlb[i].v1   : tlb[i].v0;
            end
        end
        return r;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: one cycle each in EXEC and RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    // Capture command and CP0 operands on accept; G is the AND of both page G bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q <= '0;
            op_q  <= '0;
            idx_q <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            idx_q <= cp0_index;
            cap_q <= '{vpn2: cp0_entryhi[31:13], asid: cp0_entryhi[7:0],
                       g: cp0_entrylo0[0] & cp0_entrylo1[0],
                       pfn0: cp0_entrylo0[25:6], c0: cp0_entrylo0[5:3],
                       d0: cp0_entrylo0[2], v0: cp0_entrylo0[1],
                       pfn1: cp0_entrylo1[25:6], c1: cp0_entrylo1[5:3],
                       d1: cp0_entrylo1[2], v1: cp0_entrylo1[1]};
        end
    end

    // Translation array: TLBWI lands at the end of EXEC, reset wipes every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
            tlb_used <= '0;
        end else if (state == S_EXEC && op_q == OP_TLBWI) begin
            tlb[idx_q]      <= cap_q;
            tlb_used[idx_q] <= 1'b1;
        end
    end

    // TLBR read data (unused entries read as zero) and TLBP probe result.
    always_comb begin
        rd_entry = tlb_used[idx_q] ? tlb[idx_q] : '0;
        p_hit    = lookup(cap_q.vpn2, cap_q.asid, 1'b0);
    end

    // Response registers: loaded in EXEC, held until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_op       <= '0;
            resp_index    <= '0;
            resp_entryhi  <= '0;
            resp_entrylo0 <= '0;
            resp_entrylo1 <= '0;
        end else if (state == S_EXEC) begin
            resp_op       <= op_q;
            resp_index    <= '0;
            resp_entryhi  <= '0;
            resp_entrylo0 <= '0;
            resp_entrylo1 <= '0;
            case (op_q)
                OP_TLBR: begin
                    resp_entryhi  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                    resp_entrylo0 <= {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
                    resp_entrylo1 <= {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
                end
                OP_TLBP: resp_index <= p_hit.found ? {28'b0, p_hit.idx} : 32'h8000_0000;
                default: ;
            endcase
        end
    end

    // Search port 0 combinational match.
    always_comb begin
        s0_res = lookup(s0_vaddr[31:13], s0_asid, s0_vaddr[12]);
    end

    // Search port 0 result register; data holds while no request.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_rvalid <= 1'b0;
            s0_found  <= 1'b0;
            s0_index  <= '0;
            s0_pfn    <= '0;
            s0_c      <= '0;
            s0_d      <= 1'b0;
            s0_v      <= 1'b0;
        end else begin
            s0_rvalid <= s0_valid;
            if (s0_valid) begin
                s0_found <= s0_res.found;
                s0_index <= s0_res.idx;
                s0_pfn   <= s0_res.pfn;
                s0_c     <= s0_res.c;
                s0_d     <= s0_res.d;
                s0_v     <= s0_res.v;
            end
        end
    end

`ifdef TLB_DUAL_SEARCH_EN
    srch_t s1_res;

    // Search port 1 combinational match.
    always_comb begin
        s1_res = lookup(s1_vaddr[31:13], s1_asid, s1_vaddr[12]);
    end

    // Search port 1 result register; data holds while no request.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rvalid <= 1'b0;
            s1_found  <= 1'b0;
            s1_index  <= '0;
            s1_pfn    <= '0;
            s1_c      <= '0;
            s1_d      <= 1'b0;
            s1_v      <= 1'b0;
        end else begin
            s1_rvalid <= s1_valid;
            if (s1_valid) begin
                s1_found <= s1_res.found;
                s1_index <= s1_res.idx;
                s1_pfn   <= s1_res.pfn;
                s1_c     <= s1_res.c;
                s1_d     <= s1_res.d;
                s1_v     <= s1_res.v;
            end
        end
    end

    logic unused_s1;
    assign unused_s1 = ^s1_vaddr[11:0];
`else
    // Single-port build: s1 is inert and its inputs are ignored.
    assign s1_rvalid = 1'b0;
    assign s1_found  = 1'b0;
    assign s1_index  = '0;
    assign s1_pfn    = '0;
    assign s1_c      = '0;
    assign s1_d      = 1'b0;
    assign s1_v      = 1'b0;

    logic unused_s1;
    assign unused_s1 = ^{s1_valid, s1_vaddr, s1_asid};
`endif

    // Reserved CP0 bits, page offset and probe page data carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26],
                           s0_vaddr[11:0], p_hit.pfn, p_hit.c, p_hit.d, p_hit.v};

endmodule

// File: tb/tb_tlb_cmd_unit.sv
`timescale 1ns/1ps
module tb_tlb_cmd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic [3:0]  cp0_index;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic        resp_valid;
    logic [1:0]  resp_op;
    logic [31:0] resp_index, resp_entryhi, resp_entrylo0, resp_entrylo1;
    logic        s0_valid, s0_rvalid, s0_found, s0_d, s0_v;
    logic [31:0] s0_vaddr;
    logic [7:0]  s0_asid;
    logic [3:0]  s0_index;
    logic [19:0] s0_pfn;
    logic [2:0]  s0_c;
    logic        s1_valid, s1_rvalid, s1_found, s1_d, s1_v;
    logic [31:0] s1_vaddr;
    logic [7:0]  s1_asid;
    logic [3:0]  s1_index;
    logic [19:0] s1_pfn;
    logic [2:0]  s1_c;

    int n_checks = 0;
    int n_fail   = 0;

    tlb_cmd_unit dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .resp_valid(resp_valid), .resp_op(resp_op), .resp_index(resp_index),
        .resp_entryhi(resp_entryhi), .resp_entrylo0(resp_entrylo0), .resp_entrylo1(resp_entrylo1),
        .s0_valid(s0_valid), .s0_vaddr(s0_vaddr), .s0_asid(s0_asid),
        .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_index(s0_index),
        .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_valid(s1_valid), .s1_vaddr(s1_vaddr), .s1_asid(s1_asid),
        .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_index(s1_index),
        .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  idx;
        logic [31:0] hi, lo0, lo1;
        logic [31:0] e_index, e_hi, e_lo0, e_lo1;
        logic        s_en;
        logic [31:0] s_va;
        logic [7:0]  s_asid;
        logic        e_found;
        logic [3:0]  e_sidx;
        logic [19:0] e_pfn;
        logic [2:0]  e_c;
        logic        e_d, e_v;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where resp_valid is seen (or timeout).
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [3:0] idx,
                          input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        int lat;
        check({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cp0_index = idx;
        cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        check({tag, "_cmd_ready_exec"}, 32'(cmd_ready), 32'd0);
        check({tag, "_resp_valid_exec"}, 32'(resp_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        check({tag, "_resp_latency"}, 32'(lat), 32'd2);
    endtask

    // One-cycle gap after the response: pulse gone, ready again.
    task automatic after_resp(input string tag);
        @(negedge clk);
        check({tag, "_resp_valid_drop"}, 32'(resp_valid), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_search(input string tag, input logic [31:0] va, input logic [7:0] asid,
                             input logic e_found, input logic [3:0] e_idx, input logic [19:0] e_pfn,
                             input logic [2:0] e_c, input logic e_d, input logic e_v);
        s0_valid = 1'b1; s0_vaddr = va; s0_asid = asid;
        s1_valid = 1'b1; s1_vaddr = va; s1_asid = asid;
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        check({tag, "_s0_rvalid"}, 32'(s0_rvalid), 32'd1);
        check({tag, "_s0_found"}, 32'(s0_found), 32'(e_found));
        if (e_found) begin
            check({tag, "_s0_index"}, 32'(s0_index), 32'(e_idx));
            check({tag, "_s0_pfn"}, 32'(s0_pfn), 32'(e_pfn));
            check({tag, "_s0_cdv"}, 32'({s0_c, s0_d, s0_v}), 32'({e_c, e_d, e_v}));
        end
`ifdef TLB_DUAL_SEARCH_EN
        check({tag, "_s1_rvalid"}, 32'(s1_rvalid), 32'd1);
        check({tag, "_s1_found"}, 32'(s1_found), 32'(e_found));
        if (e_found) begin
            check({tag, "_s1_index"}, 32'(s1_index), 32'(e_idx));
            check({tag, "_s1_pfn"}, 32'(s1_pfn), 32'(e_pfn));
            check({tag, "_s1_cdv"}, 32'({s1_c, s1_d, s1_v}), 32'({e_c, e_d, e_v}));
        end
`else
        check({tag, "_s1_tied"}, {s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        //          op     idx    hi            lo0           lo1           e_index       e_hi          e_lo0         e_lo1         s  s_va          asid   f  sidx   pfn        c     d     v
        vecs[0]  = '{2'b11, 4'd0,  32'h0,        32'h0,        32'h0,        32'h8000_0000, 32'h0,       32'h0,        32'h0,        1'b1, 32'h0000_0000, 8'h00, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 4'd3,  32'h1234_6005, 32'h0000_0CC6, 32'h0000_0D07, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 32'h1234_7000, 8'h05, 1'b1, 4'd3,  20'h00034, 3'd0, 1'b1, 1'b1};
        vecs[2]  = '{2'b10, 4'd3,  32'h0,        32'h0,        32'h0,        32'h0,        32'h1234_6005, 32'h0000_0CC6, 32'h0000_0D06, 1'b1, 32'h1234_6000, 8'h05, 1'b1, 4'd3,  20'h00033, 3'd0, 1'b1, 1'b1};
        vecs[3]  = '{2'b01, 4'd7,  32'h0040_0011, 32'h0000_101B, 32'h0000_1055, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 32'h0040_1000, 8'h22, 1'b1, 4'd7,  20'h00041, 3'd2, 1'b1, 1'b0};
        vecs[4]  = '{2'b11, 4'd0,  32'h0040_0022, 32'h0,        32'h0,        32'h0000_0007, 32'h0,       32'h0,        32'h0,        1'b1, 32'h0040_0000, 8'h22, 1'b1, 4'd7,  20'h00040, 3'd3, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 4'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0040_0011, 32'h0000_101B, 32'h0000_1055, 1'b1, 32'h1234_7000, 8'h06, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 4'd12, 32'h0040_0033, 32'h0000_2006, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h0040_0000, 8'h33, 1'b1, 4'd7,  20'h00040, 3'd3, 1'b0, 1'b1};
        vecs[7]  = '{2'b11, 4'd0,  32'h0040_0033, 32'h0,        32'h0,        32'h0000_0007, 32'h0,       32'h0,        32'h0,        1'b0, 32'h0,         8'h00, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 4'd12, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0040_0033, 32'h0000_2006, 32'h0000_0000, 1'b0, 32'h0,        8'h00, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 4'd15, 32'hFFFF_E0FF, 32'h03FF_FFFE, 32'h03FF_FFFF, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 32'hFFFF_E000, 8'hFF, 1'b1, 4'd15, 20'hFFFFF, 3'd7, 1'b1, 1'b1};
        vecs[10] = '{2'b10, 4'd15, 32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFF_E0FF, 32'h03FF_FFFE, 32'h03FF_FFFE, 1'b1, 32'hFFFF_F000, 8'hFE, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 4'd5,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h0000_0000, 8'h00, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};
        vecs[12] = '{2'b00, 4'd3,  32'h9999_8001, 32'h0000_1FFF, 32'h0000_1FFF, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 32'h1234_6000, 8'h05, 1'b1, 4'd3,  20'h00033, 3'd0, 1'b1, 1'b1};
        vecs[13] = '{2'b11, 4'd0,  32'h1234_6005, 32'h0,        32'h0,        32'h0000_0003, 32'h0,       32'h0,        32'h0,        1'b0, 32'h0,         8'h00, 1'b0, 4'd0,  20'h0,     3'd0, 1'b0, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cp0_index = '0;
        cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
        s0_valid = 1'b0; s0_vaddr = '0; s0_asid = '0;
        s1_valid = 1'b0; s1_vaddr = '0; s1_asid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_resp_valid_op", {resp_valid, resp_op}, 32'd0);
        check("rst_resp_data", resp_index | resp_entryhi | resp_entrylo0 | resp_entrylo1, 32'd0);
        check("rst_s0_outputs", {s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, 32'd0);
        check("rst_s1_outputs", {s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, 32'd0);

        // Table-driven command + search vectors
        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            do_cmd(t, vecs[i].op, vecs[i].idx, vecs[i].hi, vecs[i].lo0, vecs[i].lo1);
            check({t, "_resp_op"}, 32'(resp_op), 32'(vecs[i].op));
            case (vecs[i].op)
                2'b01: check({t, "_wi_data_zero"}, resp_index | resp_entryhi | resp_entrylo0 | resp_entrylo1, 32'd0);
                2'b10: begin
                    check({t, "_entryhi"}, resp_entryhi, vecs[i].e_hi);
                    check({t, "_entrylo0"}, resp_entrylo0, vecs[i].e_lo0);
                    check({t, "_entrylo1"}, resp_entrylo1, vecs[i].e_lo1);
                end
                2'b11: check({t, "_index"}, resp_index, vecs[i].e_index);
                default: ;
            endcase
            after_resp(t);
            if (vecs[i].s_en)
                do_search(t, vecs[i].s_va, vecs[i].s_asid, vecs[i].e_found, vecs[i].e_sidx,
                          vecs[i].e_pfn, vecs[i].e_c, vecs[i].e_d, vecs[i].e_v);
        end

        // Overwrite index 3 while s0 searches its old VPN2 every cycle
        @(negedge clk);
        check("ow_cmd_ready", 32'(cmd_ready), 32'd1);
        s0_valid = 1'b1; s0_vaddr = 32'h1234_6000; s0_asid = 8'h05;
        cmd_valid = 1'b1; cmd_op = 2'b01; cp0_index = 4'd3;
        cp0_entryhi = 32'h5555_4005; cp0_entrylo0 = 32'h0000_0CC6; cp0_entrylo1 = 32'h0000_0D07;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ow_found_accept", 32'(s0_found), 32'd1);
        @(negedge clk);
        check("ow_resp_valid", 32'(resp_valid), 32'd1);
        check("ow_found_exec", 32'(s0_found), 32'd1);
        @(negedge clk);
        check("ow_found_resp", 32'(s0_found), 32'd0);
        check("ow_rvalid", 32'(s0_rvalid), 32'd1);
        @(negedge clk);
        check("ow_found_later", 32'(s0_found), 32'd0);
        s0_valid = 1'b0;
        @(negedge clk);
        do_search("ow_new", 32'h5555_4000, 8'h05, 1'b1, 4'd3, 20'h00033, 3'd0, 1'b1, 1'b1);

        // Search results hold while s0_valid is low
        do_search("hold", 32'h0040_1000, 8'h22, 1'b1, 4'd7, 20'h00041, 3'd2, 1'b1, 1'b0);
        s0_vaddr = 32'h0; s0_asid = 8'h00;
        @(negedge clk);
        check("hold_rvalid", 32'(s0_rvalid), 32'd0);
        check("hold_found_idx", 32'({s0_found, s0_index}), 32'({1'b1, 4'd7}));
        check("hold_pfn", 32'(s0_pfn), 32'h00041);

        // Reset during EXEC of a TLBWI
        cmd_valid = 1'b1; cmd_op = 2'b01; cp0_index = 4'd5;
        cp0_entryhi = 32'h7777_0001; cp0_entrylo0 = 32'h0000_1006; cp0_entrylo1 = 32'h0000_1007;
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rx_resp_valid_in_reset", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rx_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rx_resp_op", 32'(resp_op), 32'd0);
        check("rx_resp_data", resp_index | resp_entryhi | resp_entrylo0 | resp_entrylo1, 32'd0);
        check("rx_s0_outputs", {s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 3; k++) begin
                if (resp_valid) seen++;
                @(negedge clk);
            end
            check("rx_no_resp_pulse", 32'(seen), 32'd0);
        end
        do_cmd("rx_tlbr", 2'b10, 4'd5, 32'h0, 32'h0, 32'h0);
        check("rx_tlbr_data", resp_entryhi | resp_entrylo0 | resp_entrylo1, 32'd0);
        after_resp("rx_tlbr");
        do_cmd("rx_tlbp", 2'b11, 4'd0, 32'h7777_0001, 32'h0, 32'h0);
        check("rx_tlbp_index", resp_index, 32'h8000_0000);
        after_resp("rx_tlbp");
        do_search("rx_s_new", 32'h7777_0000, 8'h01, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        do_search("rx_s_old", 32'h0040_0000, 8'h22, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
